// File: rtl/sad_min_scan_unit.sv
`default_nettype none
// ============================================================================
// Module   : sad_min_scan_unit
// Brief    : Sequential SAD minimum search; scans one lane per clock against a
//            running minimum that persists across batches of one search.
// Revision : 1.0
// ============================================================================
module sad_min_scan_unit #(
    parameter int               N_CH     = 8,
    parameter int               SAD_W    = 32,
    parameter int               COORD_W  = 32,
    parameter int               BATCH_W  = 8,
    parameter logic [SAD_W-1:0] INIT_MIN = '1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic [N_CH*SAD_W-1:0]      in_sad,
    input  logic [N_CH*COORD_W-1:0]    in_v1,
    input  logic [N_CH*COORD_W-1:0]    in_v0,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAD_W-1:0]           out_sad,
    output logic [COORD_W-1:0]         out_v1,
    output logic [COORD_W-1:0]         out_v0,
    output logic [$clog2(N_CH)-1:0]    out_lane,
    output logic [BATCH_W-1:0]         out_batch
);

    localparam int                LANE_W     = $clog2(N_CH);
    localparam logic [LANE_W-1:0] c_LAST_IDX = LANE_W'(N_CH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [LANE_W-1:0]        r_idx;
    logic                     r_last;
    logic [BATCH_W-1:0]       r_batch_cnt;
    logic [N_CH*SAD_W-1:0]    r_sad_buf;
    logic [N_CH*COORD_W-1:0]  r_v1_buf;
    logic [N_CH*COORD_W-1:0]  r_v0_buf;
    logic [SAD_W-1:0]         r_min;
    logic [COORD_W-1:0]       r_v1;
    logic [COORD_W-1:0]       r_v0;
    logic [LANE_W-1:0]        r_lane;
    logic [BATCH_W-1:0]       r_batch;

    logic [SAD_W-1:0]         w_lane_sad;
    logic [COORD_W-1:0]       w_lane_v1;
    logic [COORD_W-1:0]       w_lane_v0;
    logic                     w_accept;
    logic                     w_wins;

    assign w_lane_sad = r_sad_buf[SAD_W*r_idx +: SAD_W];
    assign w_lane_v1  = r_v1_buf[COORD_W*r_idx +: COORD_W];
    assign w_lane_v0  = r_v0_buf[COORD_W*r_idx +: COORD_W];
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    // <= lets ties go to the later lane and a candidate equal to INIT_MIN still win
    assign w_wins     = (w_lane_sad <= r_min);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)              w_state_nxt = S_SCAN;
            S_SCAN:  if (r_idx == c_LAST_IDX)   w_state_nxt = r_last ? S_DONE : S_IDLE;
            S_DONE:  if (out_ready)             w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_batch_cnt <= '0;
            r_sad_buf   <= '0;
            r_v1_buf    <= '0;
            r_v0_buf    <= '0;
            r_min       <= INIT_MIN;
            r_v1        <= '0;
            r_v0        <= '0;
            r_lane      <= '0;
            r_batch     <= '0;
        end else if (w_accept) begin
            r_idx     <= '0;
            r_last    <= in_last;
            r_sad_buf <= in_sad;
            r_v1_buf  <= in_v1;
            r_v0_buf  <= in_v0;
            if (in_first) begin
                r_batch_cnt <= '0;
                r_min       <= INIT_MIN;
                r_v1        <= '0;
                r_v0        <= '0;
                r_lane      <= '0;
                r_batch     <= '0;
            end else if (r_batch_cnt != '1) begin
                r_batch_cnt <= r_batch_cnt + 1'b1;
            end
        end else if (r_state == S_SCAN) begin
            r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            if (w_wins) begin
                r_min   <= w_lane_sad;
                r_v1    <= w_lane_v1;
                r_v0    <= w_lane_v0;
                r_lane  <= r_idx;
                r_batch <= r_batch_cnt;
            end
        end
    end

    assign out_sad   = r_min;
    assign out_v1    = r_v1;
    assign out_v0    = r_v0;
    assign out_lane  = r_lane;
    assign out_batch = r_batch;

endmodule
`default_nettype wire

// File: tb/tb_sad_min_scan_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_min_scan_unit
// Brief    : Directed self-checking bench for sad_min_scan_unit (N_CH=8).
// Revision : 1.0
// ============================================================================
module tb_sad_min_scan_unit;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         in_valid, in_ready, in_first, in_last;
    logic [255:0] in_sad, in_v1, in_v0;
    logic         out_valid, out_ready;
    logic [31:0]  out_sad, out_v1, out_v0;
    logic [2:0]   out_lane;
    logic [7:0]   out_batch;

    int n_checks = 0;
    int n_pass   = 0;

    sad_min_scan_unit dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .in_sad(in_sad), .in_v1(in_v1), .in_v0(in_v0),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sad(out_sad), .out_v1(out_v1), .out_v0(out_v0),
        .out_lane(out_lane), .out_batch(out_batch)
    );

    always #5 Clk = ~Clk;

    function automatic logic [255:0] pk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Presents a batch; coordinates are 0x1000/0x2000 + tag*16 + lane.
    // Returns with in_valid low, #1 after the accepting edge; n_edges includes that edge.
    task automatic send(input logic first, input logic last, input logic [255:0] sads,
                        input int tag, output int n_edges);
        in_valid = 1'b1; in_first = first; in_last = last; in_sad = sads;
        for (int i = 0; i < 8; i++) begin
            in_v1[i*32 +: 32] = 32'h1000 + 32'(tag * 16 + i);
            in_v0[i*32 +: 32] = 32'h2000 + 32'(tag * 16 + i);
        end
        n_edges = 0;
        while (!in_ready && n_edges < 100) begin
            @(posedge Clk); #1; n_edges++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge Clk); #1; n_edges++;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_valid(output int n_edges);
        n_edges = 0;
        while (!out_valid && n_edges < 100) begin
            @(posedge Clk); #1; n_edges++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1; Rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1)     $display("FAIL rst_in_ready: got %b want 1", in_ready);   else n_pass++;
        n_checks++; if (out_valid !== 1'b0)    $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_sad !== 32'hFFFFFFFF) $display("FAIL rst_out_sad: got %h want ffffffff", out_sad); else n_pass++;
        n_checks++; if (out_v1 !== 32'h0)      $display("FAIL rst_out_v1: got %h want 0", out_v1);       else n_pass++;
        n_checks++; if (out_v0 !== 32'h0)      $display("FAIL rst_out_v0: got %h want 0", out_v0);       else n_pass++;
        n_checks++; if (out_lane !== 3'd0)     $display("FAIL rst_out_lane: got %0d want 0", out_lane);  else n_pass++;
        n_checks++; if (out_batch !== 8'd0)    $display("FAIL rst_out_batch: got %0d want 0", out_batch); else n_pass++;
    endtask

    task automatic test_single_batch();
        int n, lat;
        send(1'b1, 1'b1, pk(90, 40, 70, 40, 99, 55, 60, 80), 0, n);
        wait_valid(lat);
        n_checks++; if (lat !== 8)             $display("FAIL single_latency: got %0d want 8", lat);       else n_pass++;
        n_checks++; if (out_sad !== 32'd40)    $display("FAIL single_sad: got %0d want 40", out_sad);      else n_pass++;
        n_checks++; if (out_lane !== 3'd3)     $display("FAIL single_lane: got %0d want 3", out_lane);     else n_pass++;
        n_checks++; if (out_batch !== 8'd0)    $display("FAIL single_batch: got %0d want 0", out_batch);   else n_pass++;
        n_checks++; if (out_v1 !== 32'h1003)   $display("FAIL single_v1: got %h want 1003", out_v1);       else n_pass++;
        n_checks++; if (out_v0 !== 32'h2003)   $display("FAIL single_v0: got %h want 2003", out_v0);       else n_pass++;
        release_result();
        n_checks++; if (out_valid !== 1'b0)    $display("FAIL single_release_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1)     $display("FAIL single_release_ready: got %b want 1", in_ready);  else n_pass++;
    endtask

    task automatic test_multi_batch();
        int n, lat;
        send(1'b1, 1'b0, pk(40, 35, 50, 60, 30, 45, 70, 80), 0, n);
        send(1'b0, 1'b0, pk(60, 50, 40, 30, 35, 45, 25, 90), 1, n);
        n_checks++; if (n !== 9)               $display("FAIL multi_throughput: got %0d want 9", n);       else n_pass++;
        send(1'b0, 1'b1, pk(30, 31, 32, 33, 34, 35, 36, 37), 2, n);
        wait_valid(lat);
        n_checks++; if (out_sad !== 32'd25)    $display("FAIL multi_sad: got %0d want 25", out_sad);       else n_pass++;
        n_checks++; if (out_lane !== 3'd6)     $display("FAIL multi_lane: got %0d want 6", out_lane);      else n_pass++;
        n_checks++; if (out_batch !== 8'd1)    $display("FAIL multi_batch: got %0d want 1", out_batch);    else n_pass++;
        n_checks++; if (out_v1 !== 32'h1016)   $display("FAIL multi_v1: got %h want 1016", out_v1);        else n_pass++;
        n_checks++; if (out_v0 !== 32'h2016)   $display("FAIL multi_v0: got %h want 2016", out_v0);        else n_pass++;
        release_result();
    endtask

    task automatic test_all_ones_and_hold();
        int n, lat;
        logic [31:0] f;
        f = 32'hFFFFFFFF;
        send(1'b1, 1'b1, pk(f, f, f, f, f, f, f, f), 0, n);
        wait_valid(lat);
        n_checks++; if (out_sad !== 32'hFFFFFFFF) $display("FAIL ones_sad: got %h want ffffffff", out_sad); else n_pass++;
        n_checks++; if (out_lane !== 3'd7)     $display("FAIL ones_lane: got %0d want 7", out_lane);       else n_pass++;
        n_checks++; if (out_batch !== 8'd0)    $display("FAIL ones_batch: got %0d want 0", out_batch);     else n_pass++;
        n_checks++; if (out_v1 !== 32'h1007)   $display("FAIL ones_v1: got %h want 1007", out_v1);         else n_pass++;
        n_checks++; if (out_v0 !== 32'h2007)   $display("FAIL ones_v0: got %h want 2007", out_v0);         else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL hold_handshake[%0d]: valid=%b ready=%b want 1/0", c, out_valid, in_ready); else n_pass++;
            n_checks++; if (out_sad !== 32'hFFFFFFFF || out_lane !== 3'd7 || out_v1 !== 32'h1007)
                $display("FAIL hold_outputs[%0d]: sad=%h lane=%0d v1=%h want ffffffff/7/1007", c, out_sad, out_lane, out_v1); else n_pass++;
        end
        release_result();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release: valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        int n, lat;
        send(1'b1, 1'b1, pk(20, 15, 12, 11, 30, 30, 30, 30), 0, n);
        repeat (4) @(posedge Clk);
        #1; Rst = 1'b1;
        @(posedge Clk); #1; Rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL midrst_handshake: ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
        n_checks++; if (out_sad !== 32'hFFFFFFFF) $display("FAIL midrst_sad: got %h want ffffffff", out_sad); else n_pass++;
        n_checks++; if (out_lane !== 3'd0 || out_v1 !== 32'h0 || out_v0 !== 32'h0 || out_batch !== 8'd0)
            $display("FAIL midrst_coords: lane=%0d v1=%h v0=%h batch=%0d want 0", out_lane, out_v1, out_v0, out_batch); else n_pass++;
        // Scan must not resume after reset
        repeat (10) @(posedge Clk);
        #1;
        n_checks++; if (out_valid !== 1'b0)    $display("FAIL midrst_no_result: got %b want 0", out_valid); else n_pass++;
        send(1'b1, 1'b1, pk(5, 9, 9, 9, 9, 9, 9, 9), 3, n);
        wait_valid(lat);
        n_checks++; if (out_sad !== 32'd5 || out_lane !== 3'd0 || out_v1 !== 32'h1030)
            $display("FAIL midrst_new_search: sad=%0d lane=%0d v1=%h want 5/0/1030", out_sad, out_lane, out_v1); else n_pass++;
        release_result();
    endtask

    task automatic test_back_to_back();
        int n, lat;
        send(1'b1, 1'b1, pk(30, 20, 10, 40, 50, 60, 70, 80), 1, n);
        wait_valid(lat);
        n_checks++; if (out_sad !== 32'd10)    $display("FAIL b2b_first_sad: got %0d want 10", out_sad);   else n_pass++;
        release_result();
        send(1'b1, 1'b0, pk(90, 80, 70, 60, 60, 60, 70, 80), 0, n);
        send(1'b1, 1'b1, pk(70, 65, 55, 80, 90, 50, 60, 95), 2, n);
        n_checks++; if (n !== 9)               $display("FAIL b2b_accept_delay: got %0d want 9", n);       else n_pass++;
        wait_valid(lat);
        n_checks++; if (lat !== 8)             $display("FAIL b2b_latency: got %0d want 8", lat);          else n_pass++;
        n_checks++; if (out_sad !== 32'd50)    $display("FAIL b2b_sad: got %0d want 50", out_sad);         else n_pass++;
        n_checks++; if (out_lane !== 3'd5 || out_batch !== 8'd0)
            $display("FAIL b2b_lane_batch: lane=%0d batch=%0d want 5/0", out_lane, out_batch); else n_pass++;
        n_checks++; if (out_v1 !== 32'h1025 || out_v0 !== 32'h2025)
            $display("FAIL b2b_coords: v1=%h v0=%h want 1025/2025", out_v1, out_v0); else n_pass++;
        release_result();
    endtask

    initial begin
        Rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_sad = '0; in_v1 = '0; in_v0 = '0; out_ready = 1'b0;
        test_reset();
        test_single_batch();
        test_multi_batch();
        test_all_ones_and_hold();
        test_reset_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
